// File: rtl/cube_ctrl_pkg.sv
// Shared types and defaults for the LED cube press/mode control slice.
// Holds the FSM state type, default sizing constants and a clog2 helper.
package cube_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } state_e;

  localparam int MODE_W      = 3;
  localparam int MODES       = 8;
  localparam int DTAP_WIN    = 3000000;
  localparam int IDLE_CYCLES = 60000000;

  // Minimum width of 1 so a LENGTH of 1 still yields a legal vector.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/press_mode_ctrl_window_timer.sv
// Synchronous clear/enable up-counter with a terminal-count flag.
// Saturates at LENGTH-1 so it never wraps while enabled.
module window_timer
  import cube_ctrl_pkg::*;
#(
  parameter int LENGTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = clog2(LENGTH);
  localparam logic [W-1:0] LAST = W'(LENGTH - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/press_mode_ctrl.sv
// Single-press / double-tap classifier driving the animation mode index.
// Define AUTO_CYCLE_EN to add an idle auto-advance timer.
module press_mode_ctrl
  import cube_ctrl_pkg::*;
#(
  parameter int MODES       = cube_ctrl_pkg::MODES,
  parameter int DTAP_WIN    = cube_ctrl_pkg::DTAP_WIN,
  parameter int IDLE_CYCLES = cube_ctrl_pkg::IDLE_CYCLES,
  parameter int MODE_W      = cube_ctrl_pkg::MODE_W
) (
  input  logic              clk_high,
  input  logic              rst,
  input  logic              press_pulse,
  output logic [MODE_W-1:0] mode,
  output logic              mode_change,
  output logic              double_tap,
  output logic              busy
);

  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(MODES - 1);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mc_q, mc_d;
  logic              dt_q, dt_d;
  logic              win_tc;
  logic              auto_adv;
  logic [MODE_W-1:0] mode_next;

  assign mode_next = (mode_q == LAST_MODE) ? '0 : mode_q + 1'b1;

  window_timer #(
    .LENGTH(DTAP_WIN)
  ) u_win (
    .clk(clk_high),
    .rst(rst),
    .clr(state_q == IDLE),
    .en (state_q == WAIT2),
    .tc (win_tc)
  );

`ifdef AUTO_CYCLE_EN
  logic idle_tc;

  // Restarts on expiry, on any press, and whenever a gesture is open.
  window_timer #(
    .LENGTH(IDLE_CYCLES)
  ) u_idle (
    .clk(clk_high),
    .rst(rst),
    .clr(press_pulse || (state_q != IDLE) || idle_tc),
    .en (state_q == IDLE),
    .tc (idle_tc)
  );

  assign auto_adv = idle_tc && (state_q == IDLE);
`else
  assign auto_adv = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mc_d    = 1'b0;
    dt_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_pulse) begin
          state_d = WAIT2;
        end else if (auto_adv) begin
          mode_d = mode_next;
          mc_d   = 1'b1;
        end
      end
      WAIT2: begin
        // A press on the terminal cycle still counts as a double tap.
        if (press_pulse) begin
          state_d = IDLE;
          mode_d  = '0;
          mc_d    = 1'b1;
          dt_d    = 1'b1;
        end else if (win_tc) begin
          state_d = IDLE;
          mode_d  = mode_next;
          mc_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_high) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      mc_q    <= 1'b0;
      dt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mc_q    <= mc_d;
      dt_q    <= dt_d;
    end
  end

  assign mode        = mode_q;
  assign mode_change = mc_q;
  assign double_tap  = dt_q;
  assign busy        = (state_q == WAIT2);

endmodule

// File: tb/tb_press_mode_ctrl.sv
// Directed bench for press_mode_ctrl (MODES=4, DTAP_WIN=16, IDLE_CYCLES=40).
// Cycle n is the interval following the n-th rising edge after reset release.
module tb_press_mode_ctrl;

  logic       clk_high = 1'b0;
  logic       rst = 1'b1;
  logic       press_pulse = 1'b0;
  logic [2:0] mode;
  logic       mode_change;
  logic       double_tap;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes;

  press_mode_ctrl #(
    .MODES(4),
    .DTAP_WIN(16),
    .IDLE_CYCLES(40),
    .MODE_W(3)
  ) dut (
    .clk_high   (clk_high),
    .rst        (rst),
    .press_pulse(press_pulse),
    .mode       (mode),
    .mode_change(mode_change),
    .double_tap (double_tap),
    .busy       (busy)
  );

  always #5 clk_high = ~clk_high;

  task automatic step();
    @(posedge clk_high);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    press_pulse = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic press_at(input int n);
    run_to(n);
    press_pulse = 1'b1;
    step();
    press_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d obs=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_mode", mode, 0);
    chk("rst_mc", mode_change, 0);
    chk("rst_dt", double_tap, 0);
    chk("rst_busy", busy, 0);

    // Single press at 10
    run_to(10);
    chk("sp_busy10", busy, 0);
    press_at(10);
    for (int c = 11; c <= 26; c++) begin
      run_to(c);
      chk("sp_busy", busy, 1);
      chk("sp_mc_lo", mode_change, 0);
      chk("sp_mode_hold", mode, 0);
    end
    run_to(27);
    chk("sp_mode27", mode, 1);
    chk("sp_mc27", mode_change, 1);
    chk("sp_dt27", double_tap, 0);
    chk("sp_busy27", busy, 0);
    run_to(28);
    chk("sp_mc28", mode_change, 0);
    chk("sp_mode28", mode, 1);

    // Four single presses 30 apart: 1,2,3,0
    do_reset();
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      press_at(10 + 30 * k);
      while (cyc < 27 + 30 * k) begin
        step();
        if (mode_change === 1'b1) strobes++;
      end
      chk("seq_mode", mode, (k + 1) % 4);
    end
    while (cyc < 140) begin
      step();
      if (mode_change === 1'b1) strobes++;
    end
    chk("seq_strobes", strobes, 4);
    chk("seq_final", mode, 0);

    // Double tap from mode 2
    do_reset();
    press_at(10);
    press_at(40);
    run_to(57);
    chk("dt_pre_mode", mode, 2);
    press_at(60);
    press_at(68);
    chk("dt_mode", mode, 0);
    chk("dt_mc", mode_change, 1);
    chk("dt_dt", double_tap, 1);
    chk("dt_busy", busy, 0);
    run_to(70);
    chk("dt_mc70", mode_change, 0);
    chk("dt_dt70", double_tap, 0);

    // Late second presses: offset 15, then exactly on terminal count
    do_reset();
    press_at(10);
    run_to(27);
    chk("late_pre", mode, 1);
    press_at(30);
    press_at(45);
    chk("late15_mode", mode, 0);
    chk("late15_dt", double_tap, 1);
    press_at(50);
    run_to(67);
    chk("tc_pre", mode, 1);
    press_at(70);
    press_at(86);
    chk("tc_mode", mode, 0);
    chk("tc_mc", mode_change, 1);
    chk("tc_dt", double_tap, 1);
    // Press in the return-to-IDLE cycle opens a new gesture
    press_at(87);
    chk("re_busy", busy, 1);
    chk("re_mc", mode_change, 0);
    run_to(103);
    chk("re_mode103", mode, 0);
    run_to(104);
    chk("re_mode", mode, 1);
    chk("re_mc104", mode_change, 1);
    chk("re_dt104", double_tap, 0);

    // Reset mid-window abandons the gesture
    do_reset();
    press_at(10);
    run_to(15);
    chk("mr_busy15", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_mode", mode, 0);
    chk("mr_busy", busy, 0);
    strobes = 0;
    while (cyc < 46) begin
      step();
      if (mode_change === 1'b1) strobes++;
    end
    chk("mr_no_mc", strobes, 0);

`ifdef AUTO_CYCLE_EN
    // Idle auto-advance at 40, 80, 120
    do_reset();
    for (int c = 1; c <= 121; c++) begin
      run_to(c);
      chk("auto_mc", mode_change,
          (c == 40 || c == 80 || c == 120) ? 1 : 0);
    end
    run_to(40);
    run_to(121);
    chk("auto_mode121", mode, 3);
    chk("auto_dt", double_tap, 0);

    // Press at expiry suppresses the advance
    do_reset();
    press_at(39);
    chk("sup_mc40", mode_change, 0);
    chk("sup_busy40", busy, 1);
    chk("sup_mode40", mode, 0);
    run_to(56);
    chk("sup_mode56", mode, 1);
    chk("sup_mc56", mode_change, 1);
    run_to(95);
    chk("sup_mc95", mode_change, 0);
    run_to(96);
    chk("sup_mc96", mode_change, 1);
    chk("sup_mode96", mode, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout @cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
